st_threshold_trigger: RTL and testbench



---
 rtl/st_trig_pkg.sv | 22 ++
 rtl/st_threshold_trigger.sv | 128 ++++++++++++
 tb/tb_st_threshold_trigger.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/st_trig_pkg.sv
// Shared types and widths for the self-trigger decision stage.
package st_trig_pkg;

    localparam int SAMPLE_W = 16;
    localparam int COUNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRED   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Signed maximum of two samples.
    function automatic logic signed [SAMPLE_W-1:0] smax(
        input logic signed [SAMPLE_W-1:0] a,
        input logic signed [SAMPLE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/st_threshold_trigger.sv
// Threshold self-trigger: fires once a filtered sample stream stays above a
// programmable level for MIN_WIDTH samples, reports the pulse peak when it
// falls back, then enforces a holdoff before re-arming.
module st_threshold_trigger
    import st_trig_pkg::*;
#(
    parameter int MIN_WIDTH = 4,
    parameter int HOLDOFF   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] x,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic                trigger,
    output logic                armed,
    output logic [SAMPLE_W-1:0] peak,
    output logic                peak_valid,
    output logic [COUNT_W-1:0]  trig_count
);

    localparam logic [7:0]  RUN_LAST  = 8'(MIN_WIDTH);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

    logic                       reset_reg;
    logic                       enable_reg;
    logic signed [SAMPLE_W-1:0] x_reg;
    logic signed [SAMPLE_W-1:0] thr_reg;
    logic                       above;

    state_t                     state;
    logic [7:0]                 run_cnt;
    logic [15:0]                hold_cnt;
    logic signed [SAMPLE_W-1:0] peak_acc;

    // Input registers; they keep sampling during reset so the first decision
    // after reset already sees the live level (no spurious fire at start-up).
    always_ff @(posedge clk) begin
        reset_reg  <= reset;
        enable_reg <= enable;
        if (enable_reg) begin
            x_reg   <= $signed(x);
            thr_reg <= $signed(threshold);
        end
    end

    // Strict signed compare: a sample equal to the threshold counts as below.
    assign above = (x_reg > thr_reg);

    // Trigger state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset_reg) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            hold_cnt   <= '0;
            peak_acc   <= '0;
            trigger    <= 1'b0;
            armed      <= 1'b0;
            peak       <= '0;
            peak_valid <= 1'b0;
            trig_count <= '0;
        end else begin
            trigger    <= 1'b0;
            peak_valid <= 1'b0;
            if (enable_reg) begin
                unique case (state)
                    ST_IDLE: begin
                        // Wait for a below sample so a pulse already in
                        // progress is never half-counted.
                        if (!above) begin
                            state   <= ST_ARMED;
                            armed   <= 1'b1;
                            run_cnt <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (above) begin
                            peak_acc <= (run_cnt == 8'd0) ? x_reg : smax(peak_acc, x_reg);
                            if (run_cnt + 8'd1 == RUN_LAST) begin
                                state   <= ST_FIRED;
                                armed   <= 1'b0;
                                run_cnt <= '0;
                                trigger <= 1'b1;
                                if (trig_count != '1)
                                    trig_count <= trig_count + 32'd1;
                            end else begin
                                run_cnt <= run_cnt + 8'd1;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    ST_FIRED: begin
                        // Pulse length is unbounded; track the peak until it ends.
                        if (above) begin
                            peak_acc <= smax(peak_acc, x_reg);
                        end else begin
                            peak       <= peak_acc;
                            peak_valid <= 1'b1;
                            hold_cnt   <= HOLD_LAST;
                            state      <= ST_HOLDOFF;
                        end
                    end
                    ST_HOLDOFF: begin
                        // Dead time; leaving while still above goes back to
                        // IDLE so the tail of a pulse cannot re-fire.
                        if (hold_cnt == 16'd0) begin
                            if (above) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_ARMED;
                                armed   <= 1'b1;
                                run_cnt <= '0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_st_threshold_trigger.sv
// Bench for st_threshold_trigger: directed scenarios followed by a random
// phase, every cycle checked against a sample-stream reference model.
module tb_st_threshold_trigger;

    localparam int MW = 4;
    localparam int HO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] x;
    logic [15:0] threshold;
    logic        trigger;
    logic        armed;
    logic [15:0] peak;
    logic        peak_valid;
    logic [31:0] trig_count;

    st_threshold_trigger #(.MIN_WIDTH(MW), .HOLDOFF(HO)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .x          (x),
        .threshold  (threshold),
        .trigger    (trigger),
        .armed      (armed),
        .peak       (peak),
        .peak_valid (peak_valid),
        .trig_count (trig_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int trig_seen = 0;
    int pv_seen   = 0;
    bit cmp_on    = 1'b0;

    // Reference model: pipeline copies of the controls and the sample, plus
    // a description of the trigger in terms of what the sample stream did.
    bit     m_rst_d = 1'b0;
    bit     m_en_d  = 1'b0;
    int     m_x = 0;
    int     m_thr = 0;
    bit     need_low = 1'b1;   // waiting for a below sample before arming
    bit     is_armed = 1'b0;
    bit     in_pulse = 1'b0;
    int     dead_left = 0;     // samples of dead time still to consume
    int     run_len = 0;
    int     pk = 0;
    bit     e_trig = 1'b0;
    bit     e_pv = 1'b0;
    int     e_peak = 0;
    longint e_cnt = 0;

    task automatic model_step();
        bit above;
        above = (m_x > m_thr);
        if (m_rst_d) begin
            need_low = 1'b1; is_armed = 1'b0; in_pulse = 1'b0; dead_left = 0;
            run_len = 0; pk = 0;
            e_trig = 1'b0; e_pv = 1'b0; e_peak = 0; e_cnt = 0;
        end else begin
            e_trig = 1'b0;
            e_pv   = 1'b0;
            if (m_en_d) begin
                if (need_low) begin
                    if (!above) begin need_low = 1'b0; is_armed = 1'b1; run_len = 0; end
                end else if (is_armed) begin
                    if (above) begin
                        pk = (run_len == 0 || m_x > pk) ? m_x : pk;
                        run_len++;
                        if (run_len == MW) begin
                            is_armed = 1'b0; in_pulse = 1'b1; e_trig = 1'b1;
                            if (e_cnt < 64'hFFFF_FFFF) e_cnt++;
                        end
                    end else begin
                        run_len = 0;
                    end
                end else if (in_pulse) begin
                    if (above) begin
                        if (m_x > pk) pk = m_x;
                    end else begin
                        in_pulse = 1'b0; e_peak = pk; e_pv = 1'b1; dead_left = HO;
                    end
                end else begin
                    dead_left--;
                    if (dead_left == 0) begin
                        if (above) need_low = 1'b1;
                        else begin is_armed = 1'b1; run_len = 0; end
                    end
                end
            end
        end
        if (m_en_d) begin
            m_x   = int'($signed(x));
            m_thr = int'($signed(threshold));
        end
        m_rst_d = reset;
        m_en_d  = enable;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] ep;
        @(posedge clk);
        model_step();
        #1;
        if (trigger === 1'b1) trig_seen++;
        if (peak_valid === 1'b1) pv_seen++;
        if (cmp_on) begin
            ep = 16'(e_peak);
            check("trigger",    32'(trigger),    32'(e_trig));
            check("armed",      32'(armed),      32'(is_armed));
            check("peak_valid", 32'(peak_valid), 32'(e_pv));
            check("peak",       32'(peak),       32'(ep));
            check("trig_count", trig_count,      32'(e_cnt));
        end
    endtask

    task automatic drv(input int v, input int n);
        repeat (n) begin
            x = 16'(v);
            tick();
        end
    endtask

    initial begin
        int t0;
        int p0;
        int rst_left;
        bit hi;
        int thr_i;
        int xv;

        // Reset with a large level present.
        reset = 1'b1; enable = 1'b1; x = 16'd1000; threshold = 16'd100;
        tick(); tick();
        cmp_on = 1'b1;
        tick();
        check("rst_trigger",    32'(trigger),    32'd0);
        check("rst_armed",      32'(armed),      32'd0);
        check("rst_peak",       32'(peak),       32'd0);
        check("rst_peak_valid", 32'(peak_valid), 32'd0);
        check("rst_count",      trig_count,      32'd0);

        // Level persisting out of reset must not fire.
        reset = 1'b0;
        drv(1000, 6);
        check("startup_no_fire", 32'(trig_seen), 32'd0);
        check("startup_idle",    32'(armed),     32'd0);
        drv(0, 1);
        check("arm_lat1", 32'(armed), 32'd0);
        drv(0, 1);
        check("arm_lat2", 32'(armed), 32'd1);

        // Basic fire: 0,150,200,300,250,50.
        t0 = trig_seen;
        drv(150, 1); drv(200, 1); drv(300, 1); drv(250, 1);
        check("fire_early", 32'(trigger), 32'd0);
        drv(50, 1);
        check("fire_at_t2", 32'(trigger), 32'd1);
        drv(0, 1);
        check("peak_strobe", 32'(peak_valid), 32'd1);
        check("peak_value",  32'(peak),       32'd300);
        check("count_one",   trig_count,      32'd1);
        drv(0, 14);
        check("fire_once", 32'(trig_seen - t0), 32'd1);

        // Short glitches: two 3-sample runs split by one below sample.
        t0 = trig_seen;
        drv(150, 3); drv(0, 1); drv(150, 3); drv(0, 4);
        check("glitch_no_fire", 32'(trig_seen - t0), 32'd0);

        // Equality counts as below.
        t0 = trig_seen;
        drv(100, 10);
        check("equal_no_fire", 32'(trig_seen - t0), 32'd0);
        drv(101, 4); drv(0, 2);
        check("above_by_one", 32'(trig_seen - t0), 32'd1);
        drv(0, 14);

        // Holdoff scenarios from a clean count.
        reset = 1'b1; drv(0, 3); reset = 1'b0; drv(0, 4);
        t0 = trig_seen;
        drv(150, 4); drv(0, 12); drv(150, 4); drv(0, 2);
        check("rearm_after_holdoff", 32'(trig_seen - t0), 32'd2);
        check("count_two", trig_count, 32'd2);
        drv(0, 14);
        t0 = trig_seen;
        drv(150, 4); drv(0, 3); drv(150, 4); drv(0, 14);
        check("holdoff_blocks", 32'(trig_seen - t0), 32'd1);

        // Enable gating mid-run.
        t0 = trig_seen;
        drv(150, 2);
        enable = 1'b0;
        drv(150, 5);
        check("gated_no_fire", 32'(trig_seen - t0), 32'd0);
        check("gated_armed",   32'(armed),          32'd1);
        enable = 1'b1;
        drv(150, 2); drv(0, 3);
        check("gated_resume_fire", 32'(trig_seen - t0), 32'd1);
        drv(0, 14);

        // Reset while FIRED.
        p0 = pv_seen;
        drv(150, 6);
        reset = 1'b1; drv(150, 3);
        reset = 1'b0; drv(150, 3); drv(0, 15);
        check("abort_no_peak", 32'(pv_seen - p0), 32'd0);
        check("abort_count",   trig_count,        32'd0);

        // Random phase: bursty levels, signed thresholds, enable gaps, resets.
        rst_left = 0; hi = 1'b0; thr_i = 0; threshold = 16'(thr_i);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rst_left = 3;
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) begin
                thr_i = int'($urandom_range(0, 200)) - 100;
                threshold = 16'(thr_i);
            end
            if ($urandom_range(0, 99) < 15) hi = ~hi;
            if ($urandom_range(0, 29) == 0) xv = thr_i;
            else if (hi) xv = thr_i + int'($urandom_range(1, 300));
            else xv = thr_i - int'($urandom_range(0, 200));
            drv(xv, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
